multicycle_decoder: RTL and testbench

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

---
 rtl/multicycle_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_decoder.sv
// rtl/multicycle_decoder.sv - multicycle instruction decoder FSM with handshake, memory wait and retire counter
//
// Ports:
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   Instr, instr_valid : instruction word and its valid flag
//   instr_ready        : decoder can accept an instruction (FETCH only)
//   mem_ack            : data-memory read complete, consumed in MEM
//   RegWA..PCWrite     : single-bit datapath controls
//   Show               : display select, held between write-backs
//   ALUControl         : ALU operation, driven from EXEC through WB
//   busy, illegal      : not in FETCH / parked in the error state
//   instr_count        : retired-instruction counter, wraps
module multicycle_decoder #(
    parameter int IW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] Instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          mem_ack,
    output logic          RegWA,
    output logic          RegWB,
    output logic          ImmSrc,
    output logic          IDMux,
    output logic          MemtoReg,
    output logic          JM,
    output logic          FlagW,
    output logic          IRWrite,
    output logic          PCWrite,
    output logic [1:0]    Show,
    output logic [3:0]    ALUControl,
    output logic          busy,
    output logic          illegal,
    output logic [CW-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ir;
    logic [1:0]    show_q;
    logic          accept;
    logic          retire;

    // Field decode always works on the latched IR, never on the live bus.
    logic [4:0] hi;
    logic [4:0] func;
    logic [3:0] sub;
    logic       r_type;
    logic       i_type;
    logic       unused_ir_low;

    assign hi            = ir[IW-1:IW-5];
    assign func          = ir[IW-6:IW-10];
    assign sub           = ir[IW-2:IW-5];
    assign r_type        = (hi == 5'd0);
    assign i_type        = ir[IW-1];
    assign unused_ir_low = ^ir[IW-11:0];

    logic func_legal;
    logic legal;
    logic is_nop;
    logic is_jump;
    logic is_load;

    assign func_legal = (func <= 5'd16) || ((func >= 5'd18) && (func <= 5'd20));
    assign legal      = (r_type && func_legal) || (i_type && !sub[3]);
    assign is_nop     = r_type && (func == 5'd0);
    assign is_jump    = i_type && (sub <= 4'd5);
    assign is_load    = i_type && (sub == 4'd7);

    // ALU operation for the instruction held in IR.
    logic [3:0] alu_dec;
    always_comb begin
        alu_dec = 4'd0;
        if (i_type) begin
            alu_dec = 4'b0101;
        end else if ((func >= 5'd2) && (func <= 5'd14)) begin
            alu_dec = func[3:0] - 4'd1;
        end else if ((func == 5'd16) || (func == 5'd20)) begin
            alu_dec = 4'b0010;
        end
    end

    // Write-back control values; only driven onto the ports while in WB.
    logic       wb_regwa;
    logic       wb_regwb;
    logic       wb_immsrc;
    logic       wb_idmux;
    logic       wb_memtoreg;
    logic       wb_flagw;
    logic [1:0] wb_show;

    assign wb_regwa    = (r_type && (func >= 5'd1) && (func <= 5'd16)) ||
                         (i_type && (sub[3:1] == 3'b011));
    assign wb_regwb    = r_type && (func == 5'd7);
    assign wb_immsrc   = i_type || (r_type && (func >= 5'd9) && (func <= 5'd16));
    assign wb_idmux    = r_type && ((func == 5'd15) || (func == 5'd16));
    assign wb_memtoreg = is_load;
    assign wb_flagw    = r_type && (((func >= 5'd1) && (func <= 5'd5)) ||
                                    ((func >= 5'd9) && (func <= 5'd16)) ||
                                    (func == 5'd20));
    assign wb_show     = (r_type && (func == 5'd18)) ? 2'b01 :
                         (r_type && (func == 5'd19)) ? 2'b10 : 2'b00;

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        RegWA       = 1'b0;
        RegWB       = 1'b0;
        ImmSrc      = 1'b0;
        IDMux       = 1'b0;
        MemtoReg    = 1'b0;
        JM          = 1'b0;
        FlagW       = 1'b0;
        PCWrite     = 1'b0;
        ALUControl  = 4'd0;
        Show        = show_q;
        illegal     = 1'b0;
        case (state)
            FETCH: begin
                // Gate with reset so nothing is handed over during reset.
                instr_ready = !reset;
                if (instr_valid && !reset) begin
                    accept    = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = legal ? EXEC : ERR;
            end
            EXEC: begin
                ALUControl = alu_dec;
                if (is_nop) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else if (is_jump) begin
                    PCWrite   = 1'b1;
                    JM        = 1'b1;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else if (is_load) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                ALUControl = alu_dec;
                // Ack is checked from the first MEM cycle on.
                if (mem_ack) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                ALUControl = alu_dec;
                RegWA      = wb_regwa;
                RegWB      = wb_regwb;
                ImmSrc     = wb_immsrc;
                IDMux      = wb_idmux;
                MemtoReg   = wb_memtoreg;
                FlagW      = wb_flagw;
                Show       = wb_show;
                retire     = 1'b1;
                state_nxt  = FETCH;
            end
            ERR: begin
                illegal = 1'b1;
                Show    = 2'b00;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign IRWrite = accept;
    assign busy    = (state != FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            ir          <= '0;
            instr_count <= '0;
            show_q      <= 2'b00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ir <= Instr;
            end
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
            if (state == WB) begin
                show_q <= wb_show;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_decoder.sv
// tb/tb_multicycle_decoder.sv - directed self-checking bench for multicycle_decoder
module tb_multicycle_decoder;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ack;
    logic        regwa, regwb, immsrc, idmux, memtoreg, jm, flagw, irwrite, pcwrite;
    logic [1:0]  show;
    logic [3:0]  aluc;
    logic        busy;
    logic        illegal;
    logic [3:0]  count;

    logic        reset24;
    logic [23:0] instr24;
    logic        valid24;
    logic        ready24;
    logic        ack24;
    logic        regwa24, regwb24, immsrc24, idmux24, memtoreg24, jm24, flagw24, irwrite24, pcwrite24;
    logic [1:0]  show24;
    logic [3:0]  aluc24;
    logic        busy24;
    logic        illegal24;
    logic [15:0] count24;

    int n_checks;
    int n_fail;

    multicycle_decoder #(.IW(16), .CW(4)) u_dut (
        .clk(clk), .reset(reset), .Instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_ack(mem_ack),
        .RegWA(regwa), .RegWB(regwb), .ImmSrc(immsrc), .IDMux(idmux),
        .MemtoReg(memtoreg), .JM(jm), .FlagW(flagw), .IRWrite(irwrite),
        .PCWrite(pcwrite), .Show(show), .ALUControl(aluc), .busy(busy),
        .illegal(illegal), .instr_count(count)
    );

    multicycle_decoder #(.IW(24), .CW(16)) u_dut24 (
        .clk(clk), .reset(reset24), .Instr(instr24), .instr_valid(valid24),
        .instr_ready(ready24), .mem_ack(ack24),
        .RegWA(regwa24), .RegWB(regwb24), .ImmSrc(immsrc24), .IDMux(idmux24),
        .MemtoReg(memtoreg24), .JM(jm24), .FlagW(flagw24), .IRWrite(irwrite24),
        .PCWrite(pcwrite24), .Show(show24), .ALUControl(aluc24), .busy(busy24),
        .illegal(illegal24), .instr_count(count24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in FETCH; returns one cycle after acceptance (DECODE).
    task automatic issue(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        #1;
        check("issue_irwrite", irwrite, 1'b1);
        step();
        instr_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        reset24     = 1'b1;
        instr24     = 24'h0;
        valid24     = 1'b0;
        ack24       = 1'b0;

        step();
        check("rst_ready", instr_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_count", count, 4'd0);
        check("rst_alu", aluc, 4'd0);
        check("rst_show", show, 2'd0);
        check("rst_ctrl", {regwa, regwb, immsrc, idmux, memtoreg, jm, flagw, irwrite, pcwrite}, 9'd0);
        reset   = 1'b0;
        reset24 = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1'b1);

        // func 1: WB at cycle 3, ready again at cycle 4
        issue(16'h0040);
        check("f1_decode_busy", busy, 1'b1);
        step();
        check("f1_exec_flagw", flagw, 1'b0);
        check("f1_exec_regwa", regwa, 1'b0);
        step();
        check("f1_wb_flagw", flagw, 1'b1);
        check("f1_wb_regwa", regwa, 1'b1);
        check("f1_wb_alu", aluc, 4'd0);
        check("f1_wb_count", count, 4'd0);
        step();
        check("f1_ready", instr_ready, 1'b1);
        check("f1_count", count, 4'd1);
        check("f1_flagw_off", flagw, 1'b0);

        // func 9: immediate ALU op, ALU = 8
        issue(16'h0240);
        step();
        step();
        check("f9_alu", aluc, 4'd8);
        check("f9_immsrc", immsrc, 1'b1);
        check("f9_flagw", flagw, 1'b1);
        check("f9_regwa", regwa, 1'b1);
        check("f9_idmux", idmux, 1'b0);
        step();
        check("f9_count", count, 4'd2);

        // load with ack delayed 5 cycles
        issue(16'hBC00);
        step();
        check("ld_exec_alu", aluc, 4'b0101);
        step();
        for (int i = 0; i < 5; i++) begin
            check("ld_mem_busy", busy, 1'b1);
            check("ld_mem_regwa", regwa, 1'b0);
            check("ld_mem_alu", aluc, 4'b0101);
            step();
        end
        check("ld_mem_hold", busy, 1'b1);
        mem_ack = 1'b1;
        #1;
        check("ld_mem_memtoreg", memtoreg, 1'b0);
        step();
        check("ld_wb_memtoreg", memtoreg, 1'b1);
        check("ld_wb_regwa", regwa, 1'b1);
        check("ld_wb_immsrc", immsrc, 1'b1);
        check("ld_wb_alu", aluc, 4'b0101);
        check("ld_wb_flagw", flagw, 1'b0);
        mem_ack = 1'b0;
        step();
        check("ld_ready", instr_ready, 1'b1);
        check("ld_count", count, 4'd3);

        // jump: PCWrite/JM at cycle 2, ready at cycle 3
        issue(16'h8000);
        step();
        check("jmp_pcwrite", pcwrite, 1'b1);
        check("jmp_jm", jm, 1'b1);
        check("jmp_regwa", regwa, 1'b0);
        step();
        check("jmp_ready", instr_ready, 1'b1);
        check("jmp_pcwrite_off", pcwrite, 1'b0);
        check("jmp_count", count, 4'd4);

        // func 18: Show = 01, held after WB
        issue(16'h0480);
        step();
        step();
        check("f18_show", show, 2'b01);
        check("f18_regwa", regwa, 1'b0);
        check("f18_flagw", flagw, 1'b0);
        step();
        check("f18_show_hold", show, 2'b01);
        check("f18_count", count, 4'd5);

        // func 20: FlagW, ALU = 0010, Show cleared
        issue(16'h0500);
        step();
        step();
        check("f20_flagw", flagw, 1'b1);
        check("f20_alu", aluc, 4'b0010);
        check("f20_show", show, 2'b00);
        check("f20_regwa", regwa, 1'b0);
        step();
        check("f20_count", count, 4'd6);

        // load with ack already high on MEM entry
        mem_ack = 1'b1;
        issue(16'hBC00);
        step();
        step();
        check("ld0_mem_busy", busy, 1'b1);
        check("ld0_mem_memtoreg", memtoreg, 1'b0);
        step();
        check("ld0_wb_memtoreg", memtoreg, 1'b1);
        mem_ack = 1'b0;
        step();
        check("ld0_count", count, 4'd7);

        // reset during MEM
        issue(16'hBC00);
        step();
        step();
        check("rm_mem_busy", busy, 1'b1);
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("rm_ready_in_rst", instr_ready, 1'b0);
        step();
        check("rm_busy", busy, 1'b0);
        check("rm_memtoreg", memtoreg, 1'b0);
        check("rm_regwa", regwa, 1'b0);
        check("rm_count", count, 4'd0);
        reset   = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("rm_ready", instr_ready, 1'b1);
        step();
        check("rm_no_wb", regwa, 1'b0);
        check("rm_count_hold", count, 4'd0);

        // 16 back-to-back NOPs wrap the 4-bit counter
        instr       = 16'h0000;
        instr_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            step();
            check("nop_regwa", regwa, 1'b0);
            step();
            if (k == 1)  check("nop_count1", count, 4'd1);
            if (k == 15) check("nop_count15", count, 4'd15);
            if (k == 16) check("nop_wrap", count, 4'd0);
        end
        instr_valid = 1'b0;
        #1;

        // func 17 is illegal: ERR at cycle 2, absorbing
        issue(16'h0440);
        step();
        check("ill_illegal", illegal, 1'b1);
        check("ill_ready", instr_ready, 1'b0);
        check("ill_busy", busy, 1'b1);
        check("ill_alu", aluc, 4'd0);
        instr_valid = 1'b1;
        step();
        step();
        check("ill_hold", illegal, 1'b1);
        check("ill_irwrite", irwrite, 1'b0);
        check("ill_ctrl", {regwa, regwb, immsrc, idmux, memtoreg, jm, flagw, pcwrite}, 8'd0);
        check("ill_count", count, 4'd0);
        reset = 1'b1;
        step();
        reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("ill_rst_illegal", illegal, 1'b0);
        check("ill_rst_ready", instr_ready, 1'b1);

        // I-type sub 8 and non-R/non-I prefix are illegal
        issue(16'hC000);
        step();
        check("ill_sub8", illegal, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        issue(16'h0800);
        step();
        check("ill_hi1", illegal, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;

        // IW=24, func 7
        instr24 = 24'h01C000;
        valid24 = 1'b1;
        #1;
        check("w24_irwrite", irwrite24, 1'b1);
        step();
        valid24 = 1'b0;
        step();
        check("w24_exec_alu", aluc24, 4'b0110);
        step();
        check("w24_regwa", regwa24, 1'b1);
        check("w24_regwb", regwb24, 1'b1);
        check("w24_flagw", flagw24, 1'b0);
        check("w24_alu", aluc24, 4'b0110);
        step();
        check("w24_count", count24, 16'd1);
        check("w24_ready", ready24, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
